alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller that sits on the driving side of the datapath ALU.
- Accepts one decoded-register instruction at a time over a valid/ready handshake.
- Translates opcode/funct into the 4-bit ALU control code and selects and extends operands.
- Drives the combinational ALU, captures its result and zero flag, and presents a write-back/branch packet downstream under a second valid/ready handshake.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction packet valid
- in_ready  out  1  controller can accept a packet
- in_instr  in  32  MIPS-style instruction word
- in_rs_data  in  DATA_W  value of register rs
- in_rt_data  in  DATA_W  value of register rt
- alu_op1  out  DATA_W  ALU operand 1 (registered)
- alu_op2  out  DATA_W  ALU operand 2 (registered)
- alu_sel  out  4  ALU control code (registered)
- alu_result  in  DATA_W  combinational ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result packet valid
- out_ready  in  1  downstream accepts packet
- out_result  out  DATA_W  captured ALU result
- out_zero  out  1  captured zero flag
- out_wr_en  out  1  write-back required
- out_wr_addr  out  REG_AW  destination register
- out_branch_taken  out  1  BEQ resolved taken
- out_illegal  out  1  unsupported encoding

## Operation
- Decode, R-type (opcode 000000), by funct:
  - 100100 AND → 0000
  - 100101 OR → 0001
  - 100000 ADD → 0010
  - 100010 SUB → 0110
  - 101010 SLT → 0111
  - 100111 NOR → 1100
  - R-type uses op2 = rt_data, wr_addr = rd.
- Decode, I-type by opcode:
  - 001000 ADDI → 0010, sign-extended imm
  - 001100 ANDI → 0000, zero-extended imm
  - 001101 ORI → 0001, zero-extended imm
  - 001010 SLTI → 0111, sign-extended imm
  - I-type uses wr_addr = rt.
- BEQ (opcode 000100): sel 0110, op2 = rt_data, wr_en = 0, branch_taken = alu_zero.
- op1 is always rs_data.
- Any other opcode, or any other funct under opcode 000000, is illegal: no ALU issue, out_illegal = 1, wr_en = 0, result = 0.
- FSM states:
  - IDLE: in_ready = 1. Handshake (in_valid & in_ready) latches instr/rs/rt and moves to DECODE.
  - DECODE: registers alu_op1/op2/sel. Moves to EXEC, or to DONE if illegal.
  - EXEC: samples alu_result/alu_zero into output regs. Moves to DONE.
  - DONE: out_valid = 1. Holds all out_* stable until out_ready, then goes to IDLE.
- alu_op1/op2/sel hold their last values outside DECODE; the ALU is not re-driven.
- Extension rules:
  - Sign extension replicates imm[15] to DATA_W.
  - Zero extension pads with 0.
  - Results are passed through unmodified; no overflow detection.

## Timing
- Reset (synchronous): state IDLE, in_ready = 1 on the next cycle, and all other outputs 0 (alu_sel 0000, out_* 0, out_valid 0).
- Latency for a legal instruction: handshake at edge N; alu_* valid after N+1; result captured at N+2; out_valid high after N+2.
  - In-to-out latency is 3 cycles.
- Latency for an illegal instruction: out_valid high after N+1 (2 cycles).
- out_ready high on the first out_valid cycle: packet retires that edge; in_ready high the next cycle. Minimum initiation interval is 4 cycles (legal).
- out_ready low: DONE persists indefinitely, outputs frozen, in_ready stays 0.
- in_valid outside IDLE is ignored; there is no queueing.
- rst asserted in any state, including mid-EXEC or DONE: the in-flight packet is discarded and no out_valid pulse is emitted.
- The ALU is purely combinational; alu_result must settle within one cycle of alu_* changing.

## Structure
- Package alu_pkg holds:
  - 4-bit ALU control code constants (AND, OR, ADD, SUB, SLT, NOR)
  - opcode and funct constants
  - FSM state enum (IDLE, DECODE, EXEC, DONE)
- Sub-module alu_decode (combinational): instr → sel, imm mode (none/sign/zero), wr_en, wr_addr, is_branch, illegal.
- The top holds the FSM, the input latches and the output registers.

## Test plan
- R-type ADD with rs=5, rt=7, rd=3 → alu_sel 0010, alu_op2 7; out_result 12, wr_en 1, wr_addr 3, out_valid 3 cycles after accept.
- ADDI with rs=10, imm=0xFFFF → alu_op2 0xFFFFFFFF, out_result 9. ANDI with rs=0xFFFFFFFF, imm=0x8001 → alu_op2 0x00008001.
- BEQ with rs=rt=0x55 → sel 0110, out_zero 1, branch_taken 1, wr_en 0. With rt=0x56 → branch_taken 0.
- Opcode 111111 → out_illegal 1, out_valid 2 cycles after accept, wr_en 0, alu_sel unchanged.
- out_ready held low 5 cycles, then high → outputs stable throughout; in_ready low until the cycle after retire; a second in_valid during the stall is not accepted.
- rst pulsed during EXEC → next cycle state IDLE, out_valid 0, all outputs 0; a following SUB with 9−4 yields 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALU control codes, MIPS opcode/funct
// values, FSM state codes and the decoded-instruction record.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_EXEC   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2
  } imm_mode_t;

  localparam int RIDX_W = 5;

  typedef struct packed {
    logic [3:0]        sel;
    imm_mode_t         imm;
    logic              wr_en;
    logic [RIDX_W-1:0] wr_addr;
    logic              is_branch;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: opcode/funct to ALU code, immediate mode,
// write-back target, branch and illegal flags. No state, no backpressure.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  // rs is consumed as register data upstream; shamt has no supported use here
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.wr_en   = 1'b1;
        dec.wr_addr = instr[15:11];
        case (funct)
          FN_AND:  dec.sel = ALU_AND;
          FN_OR:   dec.sel = ALU_OR;
          FN_ADD:  dec.sel = ALU_ADD;
          FN_SUB:  dec.sel = ALU_SUB;
          FN_SLT:  dec.sel = ALU_SLT;
          FN_NOR:  dec.sel = ALU_NOR;
          default: begin
            dec.illegal = 1'b1;
            dec.wr_en   = 1'b0;
            dec.wr_addr = '0;
          end
        endcase
      end
      OP_ADDI: begin
        dec.sel     = ALU_ADD;
        dec.imm     = IMM_SIGN;
        dec.wr_en   = 1'b1;
        dec.wr_addr = instr[20:16];
      end
      OP_ANDI: begin
        dec.sel     = ALU_AND;
        dec.imm     = IMM_ZERO;
        dec.wr_en   = 1'b1;
        dec.wr_addr = instr[20:16];
      end
      OP_ORI: begin
        dec.sel     = ALU_OR;
        dec.imm     = IMM_ZERO;
        dec.wr_en   = 1'b1;
        dec.wr_addr = instr[20:16];
      end
      OP_SLTI: begin
        dec.sel     = ALU_SLT;
        dec.imm     = IMM_SIGN;
        dec.wr_en   = 1'b1;
        dec.wr_addr = instr[20:16];
      end
      OP_BEQ: begin
        dec.sel       = ALU_SUB;
        dec.is_branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// One-at-a-time ALU issue: accept -> decode/drive ALU -> capture -> present packet.
// Latency 3 cycles (2 if illegal); DONE holds outputs until out_ready, in_ready only in IDLE.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_wr_en,
  output logic [REG_AW-1:0] out_wr_addr,
  output logic              out_branch_taken,
  output logic              out_illegal
);

  state_t              state;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   rt_q;
  dec_t                dec;
  logic [DATA_W-1:0]   op2_next;
  logic                wr_en_q;
  logic [REG_AW-1:0]   wr_addr_q;
  logic                is_branch_q;

  alu_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_comb begin
    case (dec.imm)
      IMM_SIGN: op2_next = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
      IMM_ZERO: op2_next = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
      default:  op2_next = rt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      instr_q          <= '0;
      rs_q             <= '0;
      rt_q             <= '0;
      alu_op1          <= '0;
      alu_op2          <= '0;
      alu_sel          <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      is_branch_q      <= 1'b0;
      out_result       <= '0;
      out_zero         <= 1'b0;
      out_wr_en        <= 1'b0;
      out_wr_addr      <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            instr_q <= in_instr;
            rs_q    <= in_rs_data;
            rt_q    <= in_rt_data;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          wr_en_q     <= dec.wr_en;
          wr_addr_q   <= REG_AW'(dec.wr_addr);
          is_branch_q <= dec.is_branch;
          // illegal encodings skip the ALU entirely so its operands stay untouched
          if (dec.illegal) begin
            out_result       <= '0;
            out_zero         <= 1'b0;
            out_wr_en        <= 1'b0;
            out_wr_addr      <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b1;
            state            <= ST_DONE;
          end else begin
            alu_op1 <= rs_q;
            alu_op2 <= op2_next;
            alu_sel <= dec.sel;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result       <= alu_result;
          out_zero         <= alu_zero;
          out_wr_en        <= wr_en_q;
          out_wr_addr      <= wr_addr_q;
          out_branch_taken <= is_branch_q & alu_zero;
          out_illegal      <= 1'b0;
          state            <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, stall/reset sequences and
// randomized instructions checked against an instruction-semantics model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic        out_branch_taken;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_rs_data       (in_rs_data),
    .in_rt_data       (in_rt_data),
    .alu_op1          (alu_op1),
    .alu_op2          (alu_op2),
    .alu_sel          (alu_sel),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_zero         (out_zero),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  // Stand-in for the datapath ALU
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_op1 | alu_op2);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  sel;
    logic [31:0] op2;
    logic [31:0] result;
    logic        zero;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        branch;
    logic        illegal;
    int          lat;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0]  last_sel = 4'd0;
  logic [31:0] last_op2 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
    return {6'b000000, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Expected packet from MIPS instruction semantics
  function automatic vec_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [3:0] psel, input logic [31:0] pop2);
    vec_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    op = ins[31:26];
    fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    e.instr = ins; e.rs = rs; e.rt = rt;
    e.sel = psel; e.op2 = pop2; e.result = 0; e.zero = 0; e.wr_en = 0;
    e.wr_addr = 0; e.branch = 0; e.illegal = 1; e.lat = 2;
    if (op == 6'b000000) begin
      e.op2 = rt; e.wr_en = 1; e.wr_addr = ins[15:11]; e.illegal = 0; e.lat = 3;
      case (fn)
        6'b100000: begin e.sel = 4'b0010; e.result = rs + rt; end
        6'b100010: begin e.sel = 4'b0110; e.result = rs - rt; end
        6'b100100: begin e.sel = 4'b0000; e.result = rs & rt; end
        6'b100101: begin e.sel = 4'b0001; e.result = rs | rt; end
        6'b100111: begin e.sel = 4'b1100; e.result = ~(rs | rt); end
        6'b101010: begin e.sel = 4'b0111; e.result = ($signed(rs) < $signed(rt)) ? 1 : 0; end
        default: begin
          e.sel = psel; e.op2 = pop2; e.wr_en = 0; e.wr_addr = 0; e.illegal = 1; e.lat = 2;
        end
      endcase
    end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) begin
      e.wr_en = 1; e.wr_addr = ins[20:16]; e.illegal = 0; e.lat = 3;
      case (op)
        6'b001000: begin e.sel = 4'b0010; e.op2 = se; e.result = rs + se; end
        6'b001100: begin e.sel = 4'b0000; e.op2 = ze; e.result = rs & ze; end
        6'b001101: begin e.sel = 4'b0001; e.op2 = ze; e.result = rs | ze; end
        default:   begin e.sel = 4'b0111; e.op2 = se; e.result = ($signed(rs) < $signed(se)) ? 1 : 0; end
      endcase
    end else if (op == 6'b000100) begin
      e.sel = 4'b0110; e.op2 = rt; e.result = rs - rt; e.branch = (rs == rt);
      e.illegal = 0; e.lat = 3;
    end
    if (!e.illegal) e.zero = (e.result == 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the packet retires.
  task automatic run_vec(input string tag, input vec_t v, input int stall);
    int lat;
    in_instr = v.instr; in_rs_data = v.rs; in_rt_data = v.rt;
    in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      total_cnt++;
      $display("FAIL %s.timeout: out_valid low after %0d cycles, expected high", tag, lat);
    end
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".alu_sel"}, {28'd0, alu_sel}, {28'd0, v.sel});
    chk({tag, ".alu_op2"}, alu_op2, v.op2);
    if (!v.illegal) chk({tag, ".alu_op1"}, alu_op1, v.rs);
    chk({tag, ".result"}, out_result, v.result);
    chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, v.zero});
    chk({tag, ".wr_en"}, {31'd0, out_wr_en}, {31'd0, v.wr_en});
    if (v.wr_en) chk({tag, ".wr_addr"}, {27'd0, out_wr_addr}, {27'd0, v.wr_addr});
    chk({tag, ".branch"}, {31'd0, out_branch_taken}, {31'd0, v.branch});
    chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, v.illegal});
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_instr = itype(6'b001101, 5'd7, 16'h00FF);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".stall_result"}, out_result, v.result);
      chk({tag, ".stall_sel"}, {28'd0, alu_sel}, {28'd0, v.sel});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".retired"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, in_ready}, 32'd1);
    if (stall > 3) begin
      for (int s = 0; s < 4; s++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".no_queued"}, {31'd0, out_valid}, 32'd0);
      end
    end
    if (!v.illegal) begin
      last_sel = v.sel;
      last_op2 = v.op2;
    end
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs_data = '0; in_rt_data = '0;

    //  instr                               rs            rt            sel      op2           result        z  we addr br il lat
    tbl[0]  = '{rtype(6'b100000, 5'd3),     32'd5,        32'd7,        4'b0010, 32'd7,        32'd12,       0, 1, 3,  0, 0, 3};
    tbl[1]  = '{itype(6'b001000, 5'd4, 16'hFFFF), 32'd10, 32'd0,        4'b0010, 32'hFFFFFFFF, 32'd9,        0, 1, 4,  0, 0, 3};
    tbl[2]  = '{itype(6'b001100, 5'd6, 16'h8001), 32'hFFFFFFFF, 32'd0,  4'b0000, 32'h00008001, 32'h00008001, 0, 1, 6,  0, 0, 3};
    tbl[3]  = '{itype(6'b000100, 5'd2, 16'h0004), 32'h55, 32'h55,       4'b0110, 32'h55,       32'd0,        1, 0, 0,  1, 0, 3};
    tbl[4]  = '{itype(6'b000100, 5'd2, 16'h0004), 32'h55, 32'h56,       4'b0110, 32'h56,       32'hFFFFFFFF, 0, 0, 0,  0, 0, 3};
    tbl[5]  = '{itype(6'b111111, 5'd2, 16'h1234), 32'd1,  32'd2,        4'b0110, 32'h56,       32'd0,        0, 0, 0,  0, 1, 2};
    tbl[6]  = '{rtype(6'b101010, 5'd9),     32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1,        32'd1,        0, 1, 9,  0, 0, 3};
    tbl[7]  = '{rtype(6'b100111, 5'd31),    32'd0,        32'hF0F0F0F0, 4'b1100, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 1, 31, 0, 0, 3};
    tbl[8]  = '{itype(6'b001101, 5'd8, 16'hABCD), 32'h12340000, 32'd0,  4'b0001, 32'h0000ABCD, 32'h1234ABCD, 0, 1, 8,  0, 0, 3};
    tbl[9]  = '{itype(6'b001010, 5'd5, 16'hFFFF), 32'd5,  32'd0,        4'b0111, 32'hFFFFFFFF, 32'd0,        1, 1, 5,  0, 0, 3};
    tbl[10] = '{rtype(6'b000000, 5'd12),    32'd3,        32'd4,        4'b0111, 32'hFFFFFFFF, 32'd0,        0, 0, 0,  0, 1, 2};
    tbl[11] = '{rtype(6'b100100, 5'd1),     32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'h0FF00FF0, 32'h0F000F00, 0, 1, 1,  0, 0, 3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("reset.alu_op1", alu_op1, 32'd0);
    chk("reset.out_result", out_result, 32'd0);
    chk("reset.out_illegal", {31'd0, out_illegal}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i], (i == 0) ? 5 : 0);

    // Reset while the instruction is in EXEC
    in_instr = rtype(6'b100000, 5'd3); in_rs_data = 32'd20; in_rt_data = 32'd22;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_exec.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exec.alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_exec.alu_op1", alu_op1, 32'd0);
    chk("rst_exec.alu_op2", alu_op2, 32'd0);
    chk("rst_exec.out_result", out_result, 32'd0);
    chk("rst_exec.out_wr_en", {31'd0, out_wr_en}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_exec.no_pulse", {31'd0, out_valid}, 32'd0);
    end
    last_sel = 4'd0;
    last_op2 = 32'd0;
    v = '{rtype(6'b100010, 5'd11), 32'd9, 32'd4, 4'b0110, 32'd4, 32'd5, 0, 1, 11, 0, 0, 3};
    run_vec("sub_after_rst", v, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [5:0]  op;
      int kind;
      kind = $urandom_range(0, 11);
      rs = $urandom();
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom();
      ins = $urandom();
      case (kind)
        0: ins = {6'b000000, ins[25:6], 6'b100000};
        1: ins = {6'b000000, ins[25:6], 6'b100010};
        2: ins = {6'b000000, ins[25:6], 6'b100100};
        3: ins = {6'b000000, ins[25:6], 6'b100101};
        4: ins = {6'b000000, ins[25:6], 6'b101010};
        5: ins = {6'b000000, ins[25:6], 6'b100111};
        6: ins = {6'b001000, ins[25:0]};
        7: ins = {6'b001100, ins[25:0]};
        8: ins = {6'b001101, ins[25:0]};
        9: ins = {6'b001010, ins[25:0]};
        10: ins = {6'b000100, ins[25:0]};
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'd0 || op == 6'd4 || op == 6'd8 || op == 6'd10 || op == 6'd12 || op == 6'd13)
            op = 6'($urandom_range(0, 63));
          ins = {op, ins[25:0]};
        end
      endcase
      v = model(ins, rs, rt, last_sel, last_op2);
      run_vec($sformatf("rnd%0d", n), v, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
